// File: rtl/bht_predictor_pkg.sv
// Shared types, opcodes and default sizing for the fetch-stage branch predictor.
// Counter reset value is derived from the counter width by counter_reset().
package bht_predictor_pkg;

  localparam int ADDR_WIDTH_DEF      = 32;
  localparam int INST_WIDTH_DEF      = 32;
  localparam int BHT_INDEX_WIDTH_DEF = 8;
  localparam int COUNTER_WIDTH_DEF   = 2;

  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
  typedef logic [INST_WIDTH_DEF-1:0] inst_t;

  localparam int OPCODE_MSB = 6;
  localparam int OPCODE_LSB = 0;

  typedef enum logic [OPCODE_MSB:OPCODE_LSB] {
    OPCODE_BR   = 7'b1100011,
    OPCODE_JALR = 7'b1100111,
    OPCODE_JAL  = 7'b1101111
  } opcode_t;

  // Weakly-not-taken: MSB clear, all lower bits set.
  function automatic int counter_reset(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  localparam int COUNTER_RESET_DEF = (1 << (COUNTER_WIDTH_DEF - 1)) - 1;

endpackage

// File: rtl/bht_predictor_imm_gen.sv
// Extracts the sign-extended J-type and B-type immediates from an instruction word.
module predictor_imm_gen
  import bht_predictor_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int INST_WIDTH = INST_WIDTH_DEF
) (
  input  logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] j_imm,
  output logic [ADDR_WIDTH-1:0] b_imm
);

  assign j_imm = {{(ADDR_WIDTH-21){inst[31]}}, inst[31], inst[19:12], inst[20],
                  inst[30:21], 1'b0};
  assign b_imm = {{(ADDR_WIDTH-13){inst[31]}}, inst[31], inst[7], inst[30:25],
                  inst[11:8], 1'b0};

  // The opcode field is decoded by the caller.
  logic unused_opcode;
  assign unused_opcode = ^inst[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: rtl/bht_predictor.sv
// Direct-mapped BHT of saturating counters: combinational IF query, ROB-driven training.
// Define PREDICTOR_BYPASS_EN to forward a same-cycle, same-index update into the query.
module bht_predictor
  import bht_predictor_pkg::*;
#(
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int INST_WIDTH      = INST_WIDTH_DEF,
  parameter int BHT_INDEX_WIDTH = BHT_INDEX_WIDTH_DEF,
  parameter int COUNTER_WIDTH   = COUNTER_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [ADDR_WIDTH-1:0] query_pc,
  input  logic [INST_WIDTH-1:0] query_inst,
  output logic                  predicted_jump,
  output logic [ADDR_WIDTH-1:0] predicted_target_pc,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic                  update_taken
);

  localparam int BHT_ENTRIES = 1 << BHT_INDEX_WIDTH;

  typedef logic [COUNTER_WIDTH-1:0] ctr_t;

  localparam ctr_t CTR_RESET = ctr_t'(counter_reset(COUNTER_WIDTH));

  ctr_t                       bht [BHT_ENTRIES];
  ctr_t                       q_ctr;
  logic [BHT_INDEX_WIDTH-1:0] q_idx;
  logic [BHT_INDEX_WIDTH-1:0] u_idx;
  logic [ADDR_WIDTH-1:0]      j_imm;
  logic [ADDR_WIDTH-1:0]      b_imm;
  logic                       update_en;

  function automatic ctr_t sat_next(input ctr_t ctr, input logic taken);
    if (taken) return (ctr == '1) ? ctr : ctr + ctr_t'(1);
    return (ctr == '0) ? ctr : ctr - ctr_t'(1);
  endfunction

  assign q_idx     = query_pc[BHT_INDEX_WIDTH+1:2];
  assign u_idx     = update_pc[BHT_INDEX_WIDTH+1:2];
  assign update_en = update_valid && rdy && !rst;

  // Word-offset and tag bits above the index are deliberately aliased away.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{query_pc[ADDR_WIDTH-1:BHT_INDEX_WIDTH+2], query_pc[1:0],
                            update_pc[ADDR_WIDTH-1:BHT_INDEX_WIDTH+2], update_pc[1:0]};

  // NOTE: the whole table is a register array, so it can be cleared in one cycle;
  // a RAM-based table would need a sweep instead. Sequential state uses <= only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_RESET;
    end else if (update_en) begin
      bht[u_idx] <= sat_next(bht[u_idx], update_taken);
    end
  end

`ifdef PREDICTOR_BYPASS_EN
  always_comb begin
    q_ctr = bht[q_idx];
    if (update_en && (u_idx == q_idx)) q_ctr = sat_next(bht[u_idx], update_taken);
  end
`else
  assign q_ctr = bht[q_idx];
`endif

  predictor_imm_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_imm_gen (
    .inst  (query_inst),
    .j_imm (j_imm),
    .b_imm (b_imm)
  );

  // NOTE: defaults assigned first so every path drives both outputs (no latch).
  always_comb begin
    predicted_jump      = 1'b0;
    predicted_target_pc = query_pc + ADDR_WIDTH'(4);
    case (query_inst[OPCODE_MSB:OPCODE_LSB])
      OPCODE_JAL: begin
        predicted_jump      = 1'b1;
        predicted_target_pc = query_pc + j_imm;
      end
      OPCODE_BR: begin
        predicted_jump = q_ctr[COUNTER_WIDTH-1];
        if (q_ctr[COUNTER_WIDTH-1]) predicted_target_pc = query_pc + b_imm;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: directed scenarios plus randomized traffic
// against an arithmetic reference model of the counter table and immediates.
module tb_bht_predictor;

  localparam int IXW  = 8;
  localparam int CW   = 2;
  localparam int NENT = 1 << IXW;
  localparam int CMAX = (1 << CW) - 1;
  localparam int CRST = (1 << (CW - 1)) - 1;
  localparam int CTHR = 1 << (CW - 1);

`ifdef PREDICTOR_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] query_pc;
  logic [31:0] query_inst;
  logic        predicted_jump;
  logic [31:0] predicted_target_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;

  int          total = 0;
  int          bad   = 0;
  int          cnt [NENT];
  logic [31:0] r_pc, r_inst, r_upd;

  bht_predictor #(
    .ADDR_WIDTH      (32),
    .INST_WIDTH      (32),
    .BHT_INDEX_WIDTH (IXW),
    .COUNTER_WIDTH   (CW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rdy                 (rdy),
    .query_pc            (query_pc),
    .query_inst          (query_inst),
    .predicted_jump      (predicted_jump),
    .predicted_target_pc (predicted_target_pc),
    .update_valid        (update_valid),
    .update_pc           (update_pc),
    .update_taken        (update_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  function automatic int next_cnt(input int c, input logic taken);
    if (taken) return (c < CMAX) ? c + 1 : c;
    return (c > 0) ? c - 1 : c;
  endfunction

  function automatic void predict(input logic [31:0] pc, input logic [31:0] inst,
                                  output logic j, output logic [31:0] t);
    logic [31:0] imm;
    int          c;
    j = 1'b0;
    t = pc + 32'd4;
    if (inst[6:0] == 7'h6F) begin
      imm = inst[31] ? 32'hFFF0_0000 : 32'd0;
      imm = imm + (32'(inst[19:12]) << 12) + (32'(inst[20]) << 11) + (32'(inst[30:21]) << 1);
      j = 1'b1;
      t = pc + imm;
    end else if (inst[6:0] == 7'h63) begin
      c = cnt[idx_of(pc)];
      if (BYP && update_valid && rdy && !rst && idx_of(update_pc) == idx_of(pc))
        c = next_cnt(c, update_taken);
      imm = inst[31] ? 32'hFFFF_F000 : 32'd0;
      imm = imm + (32'(inst[7]) << 11) + (32'(inst[30:25]) << 5) + (32'(inst[11:8]) << 1);
      j = (c >= CTHR);
      if (j) t = pc + imm;
    end
  endfunction

  // Advance one clock and mirror what the table should have done at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      foreach (cnt[i]) cnt[i] = CRST;
    end else if (rdy && update_valid) begin
      cnt[idx_of(update_pc)] = next_cnt(cnt[idx_of(update_pc)], update_taken);
    end
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken);
    update_valid = 1'b1;
    update_pc    = pc;
    update_taken = taken;
    tick();
    update_valid = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    logic        ej;
    logic [31:0] et;
    query_pc   = pc;
    query_inst = inst;
    #1;
    predict(pc, inst, ej, et);
    check({tag, "_jump"}, 32'(predicted_jump), 32'(ej));
    check({tag, "_tgt"}, predicted_target_pc, et);
  endtask

  localparam logic [31:0] BEQ8  = 32'h0000_0463;
  localparam logic [31:0] JALM  = 32'hFF5F_F06F;
  localparam logic [31:0] JALP4 = 32'h0040_006F;

  initial begin
    rst = 1'b1; rdy = 1'b1; update_valid = 1'b1; update_pc = 32'h100; update_taken = 1'b1;
    query_pc = 32'h0; query_inst = 32'h13;
    foreach (cnt[i]) cnt[i] = 0;
    tick();
    rst = 1'b0; update_valid = 1'b0;

    probe("beq_reset", 32'h100, BEQ8);
    check("beq_reset_j_const", 32'(predicted_jump), 32'd0);
    check("beq_reset_t_const", predicted_target_pc, 32'h104);

    upd(32'h100, 1'b1);
    upd(32'h100, 1'b1);
    probe("beq_trained", 32'h100, BEQ8);
    check("beq_trained_j_const", 32'(predicted_jump), 32'd1);
    check("beq_trained_t_const", predicted_target_pc, 32'h108);

    repeat (5) upd(32'h100, 1'b1);
    upd(32'h100, 1'b0);
    probe("sat_minus1", 32'h100, BEQ8);
    check("sat_minus1_j_const", 32'(predicted_jump), 32'd1);
    upd(32'h100, 1'b0);
    probe("sat_minus2", 32'h100, BEQ8);
    check("sat_minus2_j_const", 32'(predicted_jump), 32'd0);

    probe("jal_neg", 32'h200, JALM);
    check("jal_neg_t_const", predicted_target_pc, 32'h1F4);
    probe("jal_wrap", 32'hFFFF_FFFC, JALP4);
    check("jal_wrap_t_const", predicted_target_pc, 32'h0);
    probe("jalr", 32'h300, 32'h0000_8067);
    check("jalr_j_const", 32'(predicted_jump), 32'd0);

    upd(32'h500, 1'b1);
    probe("alias_100", 32'h100, BEQ8);
    check("alias_100_j_const", 32'(predicted_jump), 32'd1);
    probe("alias_104", 32'h104, BEQ8);
    check("alias_104_j_const", 32'(predicted_jump), 32'd0);
    upd(32'h100, 1'b0);
    probe("alias_500", 32'h500, BEQ8);
    check("alias_500_j_const", 32'(predicted_jump), 32'd0);

    update_valid = 1'b1; update_pc = 32'h100; update_taken = 1'b1;
    probe("same_cycle", 32'h100, BEQ8);
    check("same_cycle_j_const", 32'(predicted_jump), 32'(BYP));
    tick();
    update_valid = 1'b0;
    probe("after_same", 32'h100, BEQ8);
    check("after_same_j_const", 32'(predicted_jump), 32'd1);

    rdy = 1'b0; update_valid = 1'b1; update_pc = 32'h100; update_taken = 1'b0;
    repeat (3) tick();
    rdy = 1'b1; update_valid = 1'b0;
    probe("rdy_hold", 32'h100, BEQ8);
    check("rdy_hold_j_const", 32'(predicted_jump), 32'd1);

    repeat (4) upd(32'h100, 1'b1);
    repeat (4) upd(32'h104, 1'b1);
    probe("pre_rst_104", 32'h104, BEQ8);
    rst = 1'b1; update_valid = 1'b1; update_pc = 32'h100; update_taken = 1'b1;
    probe("during_rst", 32'h100, BEQ8);
    tick();
    rst = 1'b0; update_valid = 1'b0;
    probe("post_rst_100", 32'h100, BEQ8);
    check("post_rst_100_j_const", 32'(predicted_jump), 32'd0);
    probe("post_rst_104", 32'h104, BEQ8);
    check("post_rst_104_j_const", 32'(predicted_jump), 32'd0);
    upd(32'h100, 1'b1);
    probe("post_rst_inc", 32'h100, BEQ8);
    check("post_rst_inc_j_const", 32'(predicted_jump), 32'd1);

    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 299) == 0);
      rdy          = ($urandom_range(0, 7) != 0);
      update_valid = 1'($urandom_range(0, 1));
      update_taken = 1'($urandom_range(0, 1));
      r_upd        = $urandom;
      r_upd[9:2]   = 8'($urandom_range(0, 7));
      update_pc    = r_upd;
      r_pc         = $urandom;
      r_pc[9:2]    = 8'($urandom_range(0, 7));
      r_inst       = $urandom;
      case ($urandom_range(0, 3))
        0:       r_inst[6:0] = 7'h6F;
        1, 2:    r_inst[6:0] = 7'h63;
        default: ;
      endcase
      probe("rand", r_pc, r_inst);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
